// File: rtl/oled_spi_sink.sv
// oled_spi_sink: SPI slave that decodes SSD1351-style OLED commands into pixel writes
module oled_spi_sink #(
  parameter int c_color_bits = 16,
  parameter int c_x_size     = 128,
  parameter int c_y_size     = 128,
  parameter int c_x_bits     = $clog2(c_x_size),
  parameter int c_y_bits     = $clog2(c_y_size)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_csn,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_dc,
  input  logic                    spi_resn,
  output logic [c_x_bits-1:0]     x,
  output logic [c_y_bits-1:0]     y,
  output logic [c_color_bits-1:0] color,
  output logic                    pixel_we,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_byte,
  output logic                    write_active
);
  typedef enum logic [1:0] {IDLE, ARG, DATA} state_t;
  state_t state, state_n;
  logic [1:0] s_csn, s_clk, s_mosi, s_dc, s_resn;
  logic clk_d, rst_i, rise;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic byte_v, rx_dc, v2, is_cmd, is_dat, phase_hi;
  logic [1:0] arg_cnt, n_args;
  logic [15:0] col_w;
  logic [c_x_bits-1:0] col_start, col_end;
  logic [c_y_bits-1:0] row_start, row_end;
  assign rst_i = reset | ~s_resn[1];
  assign rise = s_clk[1] & ~clk_d & ~s_csn[1];
  assign is_cmd = v2 & ~rx_dc;
  assign is_dat = v2 & rx_dc;
  assign write_active = state == DATA;
  assign color = col_w[c_color_bits-1:0];
  // two-flop synchronizers for every SPI pin plus the spi_clk edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      s_csn <= 2'b11;
      s_clk <= 2'b00;
      s_mosi <= 2'b00;
      s_dc <= 2'b00;
      s_resn <= 2'b11;
      clk_d <= 1'b0;
    end else begin
      s_csn <= {s_csn[0], spi_csn};
      s_clk <= {s_clk[0], spi_clk};
      s_mosi <= {s_mosi[0], spi_mosi};
      s_dc <= {s_dc[0], spi_dc};
      s_resn <= {s_resn[0], spi_resn};
      clk_d <= s_clk[1];
    end
  end
  // MSB-first shifter; the extra v2 stage fixes pixel_we at four clocks after capture
  always_ff @(posedge clk) begin
    if (rst_i || s_csn[1]) begin
      cnt <= 3'd0;
      byte_v <= 1'b0;
      v2 <= 1'b0;
      rx_dc <= 1'b0;
      sr <= rst_i ? 8'd0 : sr;
    end else begin
      byte_v <= rise && cnt == 3'd7;
      v2 <= byte_v;
      if (rise) begin
        sr <= {sr[6:0], s_mosi[1]};
        cnt <= cnt + 3'd1;
        rx_dc <= cnt == 3'd7 ? s_dc[1] : rx_dc;
      end
    end
  end
  // argument count implied by each opcode
  always_comb begin
    n_args = (sr == 8'h15 || sr == 8'h75) ? 2'd2 :
             (sr == 8'hB4 || sr == 8'hC1) ? 2'd3 :
             (sr inside {8'hFD, 8'hA0, 8'hA1, 8'hA2, 8'hAB, 8'hB1, 8'hB3, 8'hB6, 8'hBE, 8'hC7, 8'hCA}) ? 2'd1 : 2'd0;
    state_n = !is_cmd ? state :
              state == ARG ? (arg_cnt == 2'd1 ? IDLE : ARG) :
              sr == 8'h5C ? DATA : n_args != 2'd0 ? ARG : IDLE;
  end
  // command decoder state register
  always_ff @(posedge clk) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  // window registers, pixel assembly and cursor advance
  always_ff @(posedge clk) begin
    if (rst_i) begin
      x <= '0;
      y <= '0;
      col_w <= 16'd0;
      pixel_we <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte <= 8'd0;
      arg_cnt <= 2'd0;
      col_start <= '0;
      col_end <= c_x_bits'(c_x_size - 1);
      row_start <= '0;
      row_end <= c_y_bits'(c_y_size - 1);
      phase_hi <= 1'b1;
    end else begin
      pixel_we <= 1'b0;
      cmd_valid <= 1'b0;
      if (s_csn[1]) phase_hi <= 1'b1;
      if (pixel_we) begin
        x <= x == col_end ? col_start : x + c_x_bits'(1);
        if (x == col_end) y <= y == row_end ? row_start : y + c_y_bits'(1);
      end
      if (is_cmd && state == ARG) begin
        arg_cnt <= arg_cnt - 2'd1;
        if (cmd_byte == 8'h15 && arg_cnt == 2'd2) col_start <= c_x_bits'(sr);
        if (cmd_byte == 8'h15 && arg_cnt == 2'd1) begin
          col_end <= c_x_bits'(sr);
          x <= col_start;
        end
        if (cmd_byte == 8'h75 && arg_cnt == 2'd2) row_start <= c_y_bits'(sr);
        if (cmd_byte == 8'h75 && arg_cnt == 2'd1) begin
          row_end <= c_y_bits'(sr);
          y <= row_start;
        end
      end else if (is_cmd) begin
        cmd_valid <= 1'b1;
        cmd_byte <= sr;
        arg_cnt <= n_args;
        phase_hi <= 1'b1;
        if (sr == 8'h5C) begin
          x <= col_start;
          y <= row_start;
        end
      end else if (is_dat && state == DATA) begin
        if (c_color_bits == 8 || !phase_hi) begin
          col_w[7:0] <= sr;
          pixel_we <= 1'b1;
          phase_hi <= 1'b1;
        end else begin
          col_w[15:8] <= sr;
          phase_hi <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_oled_spi_sink.sv
// tb_oled_spi_sink: randomized self-checking bench for oled_spi_sink against a byte-level model
module tb_oled_spi_sink;
  localparam int H = 4;
  logic clk = 1'b0;
  logic reset, spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn;
  logic [6:0] x, y, x8, y8;
  logic [15:0] color;
  logic [7:0] color8, cmd_byte, cmd_byte8;
  logic pixel_we, cmd_valid, write_active, pixel_we8, cmd_valid8, write_active8;
  int checks = 0, errors = 0;
  logic [29:0] obs_pix[$], exp_pix[$];
  logic [7:0] obs_cmd[$], exp_cmd[$];
  logic [4:0] lat_v;
  logic [13:0] pos8;
  int m_st, m_ac, m_op, m_cs, m_ce, m_rs, m_re, m_cx, m_cy, m_hi;
  bit m_ph;

  oled_spi_sink dut (.clk(clk), .reset(reset), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_resn(spi_resn), .x(x), .y(y), .color(color), .pixel_we(pixel_we),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .write_active(write_active));
  oled_spi_sink #(.c_color_bits(8)) dut8 (.clk(clk), .reset(reset), .spi_csn(spi_csn), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_resn(spi_resn), .x(x8), .y(y8), .color(color8),
    .pixel_we(pixel_we8), .cmd_valid(cmd_valid8), .cmd_byte(cmd_byte8), .write_active(write_active8));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_we) obs_pix.push_back({x, y, color});
    if (cmd_valid) obs_cmd.push_back(cmd_byte);
  end

  function automatic int nargs(int b);
    if (b == 'h15 || b == 'h75) return 2;
    if (b == 'hB4 || b == 'hC1) return 3;
    if (b inside {'hFD, 'hA0, 'hA1, 'hA2, 'hAB, 'hB1, 'hB3, 'hB6, 'hBE, 'hC7, 'hCA}) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_ac = 0; m_op = 0; m_cs = 0; m_ce = 127; m_rs = 0; m_re = 127;
    m_cx = 0; m_cy = 0; m_hi = 0; m_ph = 1;
  endfunction

  function automatic void model_byte(int b, bit dc);
    if (!dc) begin
      if (m_st == 1) begin
        if (m_op == 'h15 && m_ac == 2) m_cs = b % 128;
        if (m_op == 'h15 && m_ac == 1) begin m_ce = b % 128; m_cx = m_cs; end
        if (m_op == 'h75 && m_ac == 2) m_rs = b % 128;
        if (m_op == 'h75 && m_ac == 1) begin m_re = b % 128; m_cy = m_rs; end
        m_ac--;
        if (m_ac == 0) m_st = 0;
      end else begin
        exp_cmd.push_back(8'(b));
        m_op = b; m_ac = nargs(b); m_ph = 1;
        if (b == 'h5C) begin m_st = 2; m_cx = m_cs; m_cy = m_rs; end
        else m_st = m_ac > 0 ? 1 : 0;
      end
    end else if (m_st == 2) begin
      if (m_ph) begin m_hi = b; m_ph = 0; end
      else begin
        exp_pix.push_back({7'(m_cx), 7'(m_cy), 8'(m_hi), 8'(b)});
        m_ph = 1;
        if (m_cx == m_ce) begin m_cx = m_cs; m_cy = (m_cy == m_re) ? m_rs : (m_cy + 1) % 128; end
        else m_cx = (m_cx + 1) % 128;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit dc, input int nb, input bit lat);
    if (spi_csn) begin spi_csn = 1'b0; repeat (4) @(negedge clk); end
    spi_dc = dc;
    for (int i = 7; i >= 8 - nb; i--) begin
      spi_clk = 1'b0; spi_mosi = b[i];
      repeat (H) @(negedge clk);
      spi_clk = 1'b1;
      if (lat && i == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          lat_v[k] = pixel_we8;
          if (k == 4) pos8 = {x8, y8};
        end
      end else repeat (H) @(negedge clk);
    end
    spi_clk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit dc);
    send_byte(b, dc, 8, 1'b0);
    model_byte(b, dc);
  endtask

  task automatic csn_toggle();
    spi_clk = 1'b0; spi_csn = 1'b1;
    repeat (6) @(negedge clk);
    m_ph = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; spi_resn = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    obs_pix.delete(); exp_pix.delete(); obs_cmd.delete(); exp_cmd.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({x, y, color, pixel_we, cmd_valid, cmd_byte, write_active} !== 40'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {x, y, color, pixel_we, cmd_valid, cmd_byte, write_active});
    end
    checks++;
    if ({x8, y8, color8, pixel_we8, write_active8} !== 24'd0) begin
      errors++; $display("FAIL reset_outputs8 got %h want 0", {x8, y8, color8, pixel_we8, write_active8});
    end
    do_reset();
  endtask

  task automatic test_window();
    logic [13:0] pos [6] = '{{7'd16, 7'd32}, {7'd17, 7'd32}, {7'd18, 7'd32}, {7'd16, 7'd33}, {7'd17, 7'd33}, {7'd18, 7'd33}};
    do_reset();
    send(8'h15, 0); send(8'h10, 0); send(8'h12, 0);
    send(8'h75, 0); send(8'h20, 0); send(8'h21, 0);
    send(8'h5C, 0);
    for (int i = 0; i < 12; i++) send(8'($urandom), 1);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_pix.size() != 6) begin errors++; $display("FAIL window_count got %0d want 6", obs_pix.size()); end
    for (int i = 0; i < obs_pix.size() && i < 6; i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i] || obs_pix[i][29:16] !== pos[i]) begin
        errors++; $display("FAIL window_pix%0d got %h want %h", i, obs_pix[i], exp_pix[i]);
      end
    end
    checks++;
    if (obs_cmd.size() != 3 || obs_cmd[0] !== 8'h15 || obs_cmd[1] !== 8'h75 || obs_cmd[2] !== 8'h5C) begin
      errors++; $display("FAIL window_cmds got %0d pulses want 3", obs_cmd.size());
    end
    checks++;
    if (write_active !== 1'b1) begin errors++; $display("FAIL window_active got %b want 1", write_active); end
  endtask

  task automatic test_csn();
    do_reset();
    send(8'h5C, 0); send(8'hF8, 1); send(8'h1F, 1);
    send(8'hF8, 1); csn_toggle(); send(8'h07, 1); send(8'hE0, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_pix.size() != 2) begin errors++; $display("FAIL csn_count got %0d want 2", obs_pix.size()); end
    else begin
      checks++;
      if (obs_pix[0] !== {7'd0, 7'd0, 16'hF81F}) begin errors++; $display("FAIL csn_pix0 got %h want %h", obs_pix[0], {7'd0, 7'd0, 16'hF81F}); end
      checks++;
      if (obs_pix[1] !== {7'd1, 7'd0, 16'h07E0} || obs_pix[1] !== exp_pix[1]) begin
        errors++; $display("FAIL csn_pix1 got %h want %h", obs_pix[1], {7'd1, 7'd0, 16'h07E0});
      end
    end
  endtask

  task automatic test_arg();
    do_reset();
    send(8'hA0, 0); send(8'h5C, 0); send(8'h11, 1); send(8'h22, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (write_active !== 1'b0) begin errors++; $display("FAIL arg_active got %b want 0", write_active); end
    checks++;
    if (obs_cmd.size() != 1 || cmd_byte !== 8'hA0) begin
      errors++; $display("FAIL arg_cmd got %0d pulses byte %h want 1 pulse byte a0", obs_cmd.size(), cmd_byte);
    end
    checks++;
    if (obs_pix.size() != 0) begin errors++; $display("FAIL arg_pix got %0d want 0", obs_pix.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    send(8'h75, 0); send(8'h7E, 0); send(8'h7F, 0); send(8'h5C, 0);
    for (int i = 0; i < 257 * 2; i++) send(8'($urandom), 1);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_pix.size() != 257) begin errors++; $display("FAIL wrap_count got %0d want 257", obs_pix.size()); end
    else begin
      for (int i = 0; i < 257; i++) begin
        checks++;
        if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL wrap_pix%0d got %h want %h", i, obs_pix[i], exp_pix[i]); end
      end
      checks++;
      if (obs_pix[255][29:16] !== {7'd127, 7'd127} || obs_pix[256][29:16] !== {7'd0, 7'd126}) begin
        errors++; $display("FAIL wrap_corner got %h,%h want 3fff,007e", obs_pix[255][29:16], obs_pix[256][29:16]);
      end
    end
  endtask

  task automatic test_resn();
    do_reset();
    send(8'h15, 0); send(8'h03, 0); send(8'h05, 0); send(8'h5C, 0); send(8'hF0, 1);
    spi_resn = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({x, y, color, pixel_we, cmd_valid, cmd_byte, write_active} !== 40'd0) begin
      errors++; $display("FAIL resn_outputs got %h want 0", {x, y, color, pixel_we, cmd_valid, cmd_byte, write_active});
    end
    spi_resn = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
    obs_pix.delete(); exp_pix.delete(); obs_cmd.delete(); exp_cmd.delete();
    send(8'h12, 1); send(8'h34, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_pix.size() != 0) begin errors++; $display("FAIL resn_ignored got %0d want 0", obs_pix.size()); end
    send(8'h5C, 0); send(8'hAB, 1); send(8'hCD, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_pix.size() != 1 || obs_pix[0] !== {7'd0, 7'd0, 16'hABCD}) begin
      errors++; $display("FAIL resn_after got %0d pixels want 1 at 0,0 abcd", obs_pix.size());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'hAA, 0, 4, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_cmd.size() != 0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_pulse got %0d want 0", obs_cmd.size()); end
    send(8'h5C, 0); send(8'h12, 1); send(8'h34, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_pix.size() != 1 || obs_pix[0] !== {7'd0, 7'd0, 16'h1234}) begin
      errors++; $display("FAIL mid_reset_pix got %0d pixels want 1 at 0,0 1234", obs_pix.size());
    end
  endtask

  task automatic test_8bit();
    do_reset();
    send(8'h5C, 0);
    send_byte(8'hE3, 1, 8, 1'b1);
    model_byte(8'hE3, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (lat_v !== 5'b10000) begin errors++; $display("FAIL latency8 got %b want 10000", lat_v); end
    checks++;
    if (color8 !== 8'hE3 || pos8 !== 14'd0) begin errors++; $display("FAIL color8 got %h at %h want e3 at 0", color8, pos8); end
    checks++;
    if (cmd_byte8 !== 8'h5C || write_active8 !== 1'b1) begin
      errors++; $display("FAIL state8 got %h/%b want 5c/1", cmd_byte8, write_active8);
    end
    checks++;
    if (obs_pix.size() != 0) begin errors++; $display("FAIL half16 got %0d want 0", obs_pix.size()); end
  endtask

  task automatic test_random();
    logic [7:0] ops [8] = '{8'h15, 8'h75, 8'h5C, 8'hA0, 8'hB4, 8'hC1, 8'hAF, 8'h00};
    logic [7:0] b;
    bit dc;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      dc = $urandom_range(0, 99) < 55;
      b = 8'($urandom);
      if (!dc && m_st != 1) begin
        int p = $urandom_range(0, 7);
        if (p != 7) b = ops[p];
      end
      send(b, dc);
      if ($urandom_range(0, 19) == 0) csn_toggle();
    end
    repeat (8) @(negedge clk);
    checks++;
    if (obs_pix.size() != exp_pix.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_pix.size(), exp_pix.size()); end
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL rand_pix%0d got %h want %h", i, obs_pix[i], exp_pix[i]); end
    end
    checks++;
    if (obs_cmd != exp_cmd) begin errors++; $display("FAIL rand_cmds got %0d want %0d", obs_cmd.size(), exp_cmd.size()); end
    checks++;
    if (write_active !== (m_st == 2)) begin errors++; $display("FAIL rand_active got %b want %b", write_active, m_st == 2); end
  endtask

  initial begin
    reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0; spi_resn = 1'b1;
    lat_v = '0; pos8 = '0;
    model_reset();
    test_reset();
    test_window();
    test_csn();
    test_arg();
    test_wrap();
    test_resn();
    test_mid_reset();
    test_8bit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
